// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage feeding the instruction bitfield decoder. It owns the program
// counter, reads one word per instruction over an Avalon-style memory port,
// and latches that word into the instruction register that drives the
// decoder. The controller consumes the word with a valid/ack handshake and
// returns the next-PC decision. Fetching stops at the halt address.
//
// Optional feature (compile-time macro):
//   IFETCH_MISALIGN_CHECK_EN  - trap a misaligned PC instead of fetching it.
//                               The trap state FAULT is sticky until reset.
//                               Without the macro the low PC bits are dropped
//                               on the bus and fetch_fault is tied to 0.
//
// Handshakes:
//   memory : mem_read/mem_address are held stable while mem_waitrequest=1.
//            The word is taken on the edge where mem_read=1 and
//            mem_waitrequest=0.
//   decoder: instr_valid=1 means instr holds an unconsumed word. instr_ack is
//            sampled only while instr_valid=1; the edge that sees it clears
//            instr_valid and updates pc. pc_load is meaningful only with
//            instr_ack.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   mem_address  (out)  word-aligned byte address of the fetch
//   mem_read     (out)  read request
//   mem_waitrequest(in) memory stall
//   mem_readdata (in)   returned word
//   instr        (out)  instruction register to the decoder
//   instr_valid  (out)  instr holds a fetched, unconsumed word
//   instr_ack    (in)   controller consumed instr
//   pc_load      (in)   with instr_ack: next pc = pc_next, else pc+4
//   pc_next      (in)   branch/jump target
//   pc           (out)  address of the word in instr / being fetched
//   active       (out)  low once the halt address has been reached
//   fetch_fault  (out)  misaligned PC trap
//   state_dbg    (out)  current FSM state, for observation only
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] mem_address,
   output logic        mem_read,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ack,
   input  logic        pc_load,
   input  logic [31:0] pc_next,
   output logic [31:0] pc,
   output logic        active,
   output logic        fetch_fault,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_HOLD   = 3'd2,
      S_HALTED = 3'd3,
      S_FAULT  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] pc_target;

   // Next PC on ack; pc+4 wraps naturally in 32 bits.
   assign pc_target = pc_load ? pc_next : (pc_q + 32'd4);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_VECTOR;
         instr_q       <= 32'd0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (pc_q[1:0] != 2'b00) state_d = S_FAULT;
`endif
         end
         S_FETCH: begin
            if (!mem_waitrequest) begin
               instr_d       = mem_readdata;
               instr_valid_d = 1'b1;
               state_d       = S_HOLD;
            end
         end
         S_HOLD: begin
            // instr is deliberately kept after ack; the decoder may still look.
            if (instr_ack) begin
               instr_valid_d = 1'b0;
               pc_d          = pc_target;
               if (pc_target == HALT_ADDR) begin
                  state_d = S_HALTED;
               end else begin
                  state_d = S_FETCH;
`ifdef IFETCH_MISALIGN_CHECK_EN
                  // Trap before a read is ever issued for the bad address.
                  if (pc_target[1:0] != 2'b00) state_d = S_FAULT;
`endif
               end
            end
         end
         S_HALTED: begin
            instr_valid_d = 1'b0;
         end
         S_FAULT: begin
            instr_valid_d = 1'b0;
         end
         default: begin
            state_d       = S_IDLE;
            instr_valid_d = 1'b0;
         end
      endcase
   end

   // The read strobe decodes straight from state so an asynchronous reset
   // drops it immediately and abandons any stalled transaction.
   assign mem_read    = (state_q == S_FETCH);
   assign mem_address = {pc_q[31:2], 2'b00};
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign active      = (state_q != S_HALTED);
   assign state_dbg   = state_q;

`ifdef IFETCH_MISALIGN_CHECK_EN
   assign fetch_fault = (state_q == S_FAULT);
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Bench for instruction_fetch. A behavioural memory returns a word derived
// from the address. Every PC the controller side decides on is pushed to
// exp_q; each fetch pops it and checks the bus address, the latched word and
// the pc seen by the decoder. Also covers reset values, wait states, ignored
// controller inputs, pc wrap into the halt address, reset during a stalled
// read and the misaligned-PC behaviour in both builds.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam logic [31:0] RV = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ack;
   logic        pc_load;
   logic [31:0] pc_next;
   logic [31:0] pc;
   logic        active;
   logic        fetch_fault;
   logic [2:0]  state_dbg;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;
   logic [31:0] tgt;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   instruction_fetch dut (
      .clk             (clk),
      .reset           (reset),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_waitrequest (mem_waitrequest),
      .mem_readdata    (mem_readdata),
      .instr           (instr),
      .instr_valid     (instr_valid),
      .instr_ack       (instr_ack),
      .pc_load         (pc_load),
      .pc_next         (pc_next),
      .pc              (pc),
      .active          (active),
      .fetch_fault     (fetch_fault),
      .state_dbg       (state_dbg)
   );

   // ---------------- memory model ----------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RV) return 32'h2402000A;
      return a ^ 32'h5A5AA5A5;
   endfunction

   always_comb mem_readdata = mem_word(mem_address);

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a falling edge where a fetch should be in progress. Holds
   // waitrequest for 'waits' cycles; with 'noise' the controller inputs are
   // toggled during the stall and must be ignored.
   task automatic fetch_cycle(input int waits, input bit noise);
      logic [31:0] p;
      if (exp_q.size() == 0) begin
         check_eq("exp_q_underflow", 32'd1, 32'd0);
         return;
      end
      p = exp_q.pop_front();
      for (int i = 0; i <= waits; i++) begin
         check_eq("rd_req", 32'(mem_read), 32'd1);
         check_eq("rd_addr", mem_address, {p[31:2], 2'b00});
         check_eq("fetch_pc", pc, p);
         check_eq("fetch_valid_lo", 32'(instr_valid), 32'd0);
         mem_waitrequest = (i < waits);
         if (noise && (i < waits)) begin
            instr_ack = 1'b1;
            pc_load   = 1'b1;
            pc_next   = $urandom;
         end else begin
            instr_ack = 1'b0;
            pc_load   = 1'b0;
         end
         @(negedge clk);
      end
      instr_ack       = 1'b0;
      pc_load         = 1'b0;
      mem_waitrequest = 1'b0;
      check_eq("valid_hi", 32'(instr_valid), 32'd1);
      check_eq("instr", instr, mem_word({p[31:2], 2'b00}));
      check_eq("hold_pc", pc, p);
      check_eq("rd_drop", 32'(mem_read), 32'd0);
      exp_pc = p;
   endtask

   // Called at a falling edge in HOLD. First a pc_load without ack (ignored),
   // then the real ack. Returns the pc the stage must move to.
   task automatic do_ack(input bit load, input logic [31:0] target_in, output logic [31:0] t);
      t = load ? target_in : (exp_pc + 32'd4);
      instr_ack = 1'b0;
      pc_load   = 1'b1;
      pc_next   = 32'h12345678;
      @(negedge clk);
      check_eq("noack_valid", 32'(instr_valid), 32'd1);
      check_eq("noack_pc", pc, exp_pc);
      instr_ack = 1'b1;
      pc_load   = load;
      pc_next   = target_in;
      @(negedge clk);
      instr_ack = 1'b0;
      pc_load   = 1'b0;
      check_eq("ack_valid_lo", 32'(instr_valid), 32'd0);
      check_eq("ack_pc", pc, t);
      check_eq("ack_instr_kept", instr, mem_word({exp_pc[31:2], 2'b00}));
      exp_pc = t;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset           = 1'b1;
      mem_waitrequest = 1'b0;
      instr_ack       = 1'b0;
      pc_load         = 1'b0;
      pc_next         = 32'd0;
      repeat (3) @(negedge clk);

      check_eq("rst_pc", pc, RV);
      check_eq("rst_instr", instr, 32'd0);
      check_eq("rst_valid", 32'(instr_valid), 32'd0);
      check_eq("rst_read", 32'(mem_read), 32'd0);
      check_eq("rst_active", 32'(active), 32'd1);
      check_eq("rst_fault", 32'(fetch_fault), 32'd0);

      // Release: one IDLE cycle, then read, word valid the cycle after.
      reset = 1'b0;
      exp_q.push_back(RV);
      @(negedge clk);
      fetch_cycle(0, 1'b0);

      // Sequential ack, fetch stalled 3 cycles with ignored controller noise.
      do_ack(1'b0, 32'd0, tgt);
      exp_q.push_back(tgt);
      fetch_cycle(3, 1'b1);

      // Jump.
      do_ack(1'b1, 32'hBFC00100, tgt);
      exp_q.push_back(tgt);
      fetch_cycle($urandom_range(0, 2), 1'b1);

      // Jump to the last word, then pc+4 wraps to 0 = halt address.
      do_ack(1'b1, 32'hFFFFFFFC, tgt);
      exp_q.push_back(tgt);
      fetch_cycle(0, 1'b0);
      do_ack(1'b0, 32'd0, tgt);
      check_eq("halt_active", 32'(active), 32'd0);
      check_eq("halt_read", 32'(mem_read), 32'd0);
      for (int i = 0; i < 4; i++) begin
         instr_ack       = 1'b1;
         pc_load         = 1'($urandom_range(0, 1));
         pc_next         = RV;
         mem_waitrequest = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_eq("halted_active", 32'(active), 32'd0);
         check_eq("halted_read", 32'(mem_read), 32'd0);
         check_eq("halted_valid", 32'(instr_valid), 32'd0);
         check_eq("halted_pc", pc, 32'd0);
      end
      instr_ack       = 1'b0;
      pc_load         = 1'b0;
      mem_waitrequest = 1'b0;

      // Reset during a stalled read.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.push_back(RV);
      @(negedge clk);
      check_eq("pre_abort_read", 32'(mem_read), 32'd1);
      mem_waitrequest = 1'b1;
      @(negedge clk);
      check_eq("stalled_read", 32'(mem_read), 32'd1);
      reset = 1'b1;
      #1;
      check_eq("abort_read", 32'(mem_read), 32'd0);
      check_eq("abort_pc", pc, RV);
      @(negedge clk);
      reset           = 1'b0;
      mem_waitrequest = 1'b0;
      @(negedge clk);
      fetch_cycle(0, 1'b0);
      do_ack(1'b0, 32'd0, tgt);
      exp_q.push_back(tgt);
      fetch_cycle(0, 1'b0);

      // Misaligned target.
      do_ack(1'b1, 32'hBFC00102, tgt);
`ifdef IFETCH_MISALIGN_CHECK_EN
      for (int i = 0; i < 3; i++) begin
         check_eq("fault_flag", 32'(fetch_fault), 32'd1);
         check_eq("fault_read", 32'(mem_read), 32'd0);
         check_eq("fault_valid", 32'(instr_valid), 32'd0);
         check_eq("fault_active", 32'(active), 32'd1);
         instr_ack = 1'b1;
         pc_load   = 1'b1;
         pc_next   = RV;
         @(negedge clk);
      end
      instr_ack = 1'b0;
      pc_load   = 1'b0;
`else
      exp_q.push_back(tgt);
      fetch_cycle(0, 1'b0);
      check_eq("no_fault", 32'(fetch_fault), 32'd0);
`endif

      check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
